// File: rtl/axi_apb_pkg.sv
// Shared FSM state, grant and AXI response encodings for the AXI4-Lite to APB front end.
// Consumers select the optional SLVERR mapping with AXI2APB_ERR_RESP_EN.
package axi_apb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_DATA,
        B_RESP,
        R_RESP
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [1:0] resp_from_err(input logic slverr);
        return slverr ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_hold_slot.sv
// One-deep valid/data holding register; ready while empty and out of reset,
// fills on load&ready and empties on clear.
module axi_hold_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] dout
);

    assign ready = !full && !rst;

    // Load has priority, though load and clear never coincide since ready means empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            dout <= '0;
        end else if (load && ready) begin
            full <= 1'b1;
            dout <= din;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4lite_apb_frontend.sv
// AXI4-Lite slave front end feeding a downstream APB master one transfer at a time.
// Define AXI2APB_ERR_RESP_EN to map a latched PSLVERR onto BRESP/RRESP = SLVERR.
module axi4lite_apb_frontend
    import axi_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic                    transfer,
    output logic                    read,
    output logic                    write,
    output logic [ADDR_WIDTH-1:0]   apb_waddr,
    output logic [ADDR_WIDTH-1:0]   apb_raddr,
    output logic [DATA_WIDTH-1:0]   apb_wdata,
    input  logic [DATA_WIDTH-1:0]   apb_rdata,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    state_t state;
    grant_t last_grant;
    logic   aw_full, w_full, ar_full;
    logic   xfer_q, complete, wr_done, rd_done;
    logic   wr_elig, rd_elig, unused;

    assign complete = PSEL && PENABLE && PREADY;
    assign wr_done  = (state == WR_ISSUE) && complete;
    assign rd_done  = (state == RD_ISSUE) && complete;
    assign wr_elig  = aw_full && w_full;
    assign rd_elig  = ar_full;

    // Dropping the request in the completion cycle keeps the APB master from starting a second transfer.
    assign transfer = xfer_q && !complete;

    axi_hold_slot #(.WIDTH(ADDR_WIDTH)) u_aw_slot (
        .clk(PCLK), .rst(PRESET), .load(AWVALID), .clear(wr_done),
        .din(AWADDR), .ready(AWREADY), .full(aw_full), .dout(apb_waddr)
    );

    axi_hold_slot #(.WIDTH(DATA_WIDTH)) u_w_slot (
        .clk(PCLK), .rst(PRESET), .load(WVALID), .clear(wr_done),
        .din(WDATA), .ready(WREADY), .full(w_full), .dout(apb_wdata)
    );

    axi_hold_slot #(.WIDTH(ADDR_WIDTH)) u_ar_slot (
        .clk(PCLK), .rst(PRESET), .load(ARVALID), .clear(rd_done),
        .din(ARADDR), .ready(ARREADY), .full(ar_full), .dout(apb_raddr)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= IDLE;
            last_grant <= GRANT_RD;
            xfer_q     <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            BVALID     <= 1'b0;
            RVALID     <= 1'b0;
            RDATA      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // On a tie the direction not served last time wins.
                    if (wr_elig && (!rd_elig || last_grant == GRANT_RD)) begin
                        state      <= WR_ISSUE;
                        last_grant <= GRANT_WR;
                        xfer_q     <= 1'b1;
                        write      <= 1'b1;
                    end else if (rd_elig) begin
                        state      <= RD_ISSUE;
                        last_grant <= GRANT_RD;
                        xfer_q     <= 1'b1;
                        read       <= 1'b1;
                    end
                end
                WR_ISSUE: begin
                    if (complete) begin
                        state  <= B_RESP;
                        xfer_q <= 1'b0;
                        write  <= 1'b0;
                        BVALID <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    if (complete) begin
                        state  <= RD_DATA;
                        xfer_q <= 1'b0;
                        read   <= 1'b0;
                    end
                end
                RD_DATA: begin
                    state  <= R_RESP;
                    RDATA  <= apb_rdata;
                    RVALID <= 1'b1;
                end
                B_RESP: begin
                    if (BREADY) begin
                        state  <= IDLE;
                        BVALID <= 1'b0;
                    end
                end
                R_RESP: begin
                    if (RREADY) begin
                        state  <= IDLE;
                        RVALID <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI2APB_ERR_RESP_EN
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            BRESP <= RESP_OKAY;
            RRESP <= RESP_OKAY;
        end else begin
            if (wr_done) BRESP <= resp_from_err(PSLVERR);
            if (rd_done) RRESP <= resp_from_err(PSLVERR);
        end
    end

    assign unused = ^WSTRB;
`else
    assign BRESP  = RESP_OKAY;
    assign RRESP  = RESP_OKAY;
    assign unused = ^{WSTRB, PSLVERR};
`endif

endmodule
